// File: rtl/core_biu_dmem_resp.sv
// Data-memory responder for the LSU load/store port: services one word access per
// request from an internal array after LATENCY cycles and returns data/error.
//
// state  | meaning
// IDLE   | waiting for a request (req_ready_o=1)
// BUSY   | latency countdown after acceptance
// RESP   | response presented, waiting for rsp_ready_i
module core_biu_dmem_resp #(
    parameter int              XLEN       = 32,
    parameter int              WMASK_W    = XLEN / 8,
    parameter int              DEPTH_LOG2 = 10,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int              LATENCY    = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [XLEN-1:0]    req_addr_i,
    input  logic               req_wen_i,
    input  logic [XLEN-1:0]    req_wdata_i,
    input  logic [WMASK_W-1:0] req_wmask_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [XLEN-1:0]    rsp_rdata_o,
    output logic               rsp_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    logic [XLEN-1:0] mem_q [2**DEPTH_LOG2];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  wen_q, wen_d;
    logic                  inr_q, inr_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [XLEN-1:0]       off;
    logic                  req_inr;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  accept;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_wen;
    logic                  rd_inr;
    logic                  load_rsp;
    logic                  unused_off;

    // Unsigned subtraction wraps below BASE_ADDR, so the explicit >= catches underflow.
    assign off        = req_addr_i - BASE_ADDR;
    assign req_inr    = (req_addr_i >= BASE_ADDR) && (off[XLEN-1:DEPTH_LOG2+2] == '0);
    assign req_idx    = off[DEPTH_LOG2+1:2];
    assign unused_off = ^off[1:0];

    assign accept = (state_q == S_IDLE) && req_valid_i;
    assign mem_we = accept && req_wen_i && req_inr;

    // With LATENCY==1 the response is loaded on the accept edge, straight from the request.
    assign rd_idx = (state_q == S_IDLE) ? req_idx   : idx_q;
    assign rd_wen = (state_q == S_IDLE) ? req_wen_i : wen_q;
    assign rd_inr = (state_q == S_IDLE) ? req_inr   : inr_q;

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wen_d    = wen_q;
        inr_d    = inr_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        load_rsp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d = req_idx;
                    wen_d = req_wen_i;
                    inr_d = req_inr;
                    if (LATENCY == 1) begin
                        state_d  = S_RESP;
                        load_rsp = 1'b1;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_RESP;
                    load_rsp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (load_rsp) begin
            rdata_d = (!rd_wen && rd_inr) ? mem_q[rd_idx] : '0;
            err_d   = !rd_inr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            inr_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            inr_q   <= inr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; writes land on the acceptance edge.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && mem_we) begin
            for (int i = 0; i < WMASK_W; i++) begin
                if (req_wmask_i[i]) mem_q[req_idx][8*i +: 8] <= req_wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_core_biu_dmem_resp.sv
// Bench for core_biu_dmem_resp: three instances (LATENCY 1, 2, 5) checked against a
// word-array reference model, a directed vector table and hand-written corner sequences.
module tb_core_biu_dmem_resp;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr  [3];
    logic        req_wen   [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_wmask [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [31:0] model_mem [3][WORDS];
    bit          model_wr  [3][WORDS];

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        core_biu_dmem_resp #(.LATENCY(g == 0 ? 1 : (g == 1 ? 2 : 5))) u_dut (
            .clk_i      (clk),
            .rst_n_i    (rst_n[g]),
            .req_valid_i(req_valid[g]),
            .req_ready_o(req_ready[g]),
            .req_addr_i (req_addr[g]),
            .req_wen_i  (req_wen[g]),
            .req_wdata_i(req_wdata[g]),
            .req_wmask_i(req_wmask[g]),
            .rsp_valid_o(rsp_valid[g]),
            .rsp_ready_i(rsp_ready[g]),
            .rsp_rdata_o(rsp_rdata[g]),
            .rsp_err_o  (rsp_err[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 5);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        longint la = longint'(a);
        longint lb = longint'(BASE);
        return (la >= lb) && ((la - lb) / 4 < WORDS);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 2) % WORDS;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_write(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wmask);
        int k;
        if (!in_rng(addr)) return;
        k = idx_of(addr);
        if (!model_wr[d][k]) model_mem[d][k] = 32'h0;
        for (int b = 0; b < 4; b++)
            if (wmask[b]) model_mem[d][k][8*b +: 8] = wdata[8*b +: 8];
        // Unwritten lanes of a never-written word are unknown; only full masks make it known.
        if (model_wr[d][k] || wmask == 4'hF) model_wr[d][k] = 1'b1;
    endtask

    // One complete transaction with rsp_ready held high; checks latency, err and data.
    task automatic run_txn(input int d, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask,
                           output logic [31:0] rdata, output logic err, output int acc);
        int          n;
        bit          busy_ok;
        bit          exp_err;
        bit          exp_known;
        logic [31:0] exp_rd;
        rdata     = 32'h0;
        err       = 1'b0;
        acc       = 0;
        exp_err   = !in_rng(addr);
        exp_known = 1'b1;
        exp_rd    = 32'h0;
        if (!wen && !exp_err) begin
            exp_known = model_wr[d][idx_of(addr)];
            exp_rd    = model_mem[d][idx_of(addr)];
        end
        if (wen) model_write(d, addr, wdata, wmask);

        @(negedge clk);
        rsp_ready[d] = 1'b1;
        req_valid[d] = 1'b1;
        req_wen[d]   = wen;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_wmask[d] = wmask;
        n = 0;
        while (!req_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("req_ready timeout", 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom();
        n = 0;
        busy_ok = 1'b1;
        while (!rsp_valid[d] && n < 50) begin
            if (req_ready[d]) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("rsp_valid timeout", 32'(rsp_valid[d]), 32'd1);
            return;
        end
        if (req_ready[d]) busy_ok = 1'b0;
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        chk($sformatf("latency d%0d", d), 32'(cyc - acc), 32'(lat_of(d) - 1));
        chk($sformatf("req_ready low while busy d%0d", d), 32'(busy_ok), 32'd1);
        chk($sformatf("rsp_err d%0d addr %h", d, addr), 32'(err), 32'(exp_err));
        if (exp_known) chk($sformatf("rsp_rdata d%0d addr %h", d, addr), rdata, exp_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          acc;
        int          prev;
        int          n;
        bit          quiet;

        for (int d = 0; d < 3; d++) begin
            rst_n[d]     = 1'b0;
            req_valid[d] = 1'b0;
            req_addr[d]  = 32'h0;
            req_wen[d]   = 1'b0;
            req_wdata[d] = 32'h0;
            req_wmask[d] = 4'h0;
            rsp_ready[d] = 1'b1;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset rsp_valid d%0d", d), 32'(rsp_valid[d]), 32'd0);
            chk($sformatf("reset rsp_rdata d%0d", d), rsp_rdata[d], 32'd0);
            chk($sformatf("reset rsp_err d%0d", d), 32'(rsp_err[d]), 32'd0);
            chk($sformatf("reset req_ready d%0d", d), 32'(req_ready[d]), 32'd1);
            rst_n[d] = 1'b1;
        end

        // Directed table on the LATENCY=2 instance.
        tbl[0]  = '{1'b1, BASE + 32'h10,  32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, BASE + 32'h10,  32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, BASE + 32'h10,  32'h0000_AA00, 4'h2, 32'h0,         1'b0};
        tbl[3]  = '{1'b0, BASE + 32'h10,  32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
        tbl[4]  = '{1'b1, BASE + 32'h10,  32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
        tbl[5]  = '{1'b0, BASE + 32'h13,  32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
        tbl[6]  = '{1'b1, BASE,           32'h1234_5678, 4'hF, 32'h0,         1'b0};
        tbl[7]  = '{1'b1, BASE + 32'h1000, 32'hCAFE_F00D, 4'hF, 32'h0,        1'b1};
        tbl[8]  = '{1'b0, BASE,           32'h0,         4'h0, 32'h1234_5678, 1'b0};
        tbl[9]  = '{1'b0, BASE - 32'h4,   32'h0,         4'h0, 32'h0,         1'b1};
        tbl[10] = '{1'b1, BASE - 32'h4,   32'h1122_3344, 4'hF, 32'h0,         1'b1};
        tbl[11] = '{1'b1, BASE + 32'hFFC, 32'hAABB_CCDD, 4'hF, 32'h0,         1'b0};
        tbl[12] = '{1'b1, BASE + 32'hFFC, 32'h9900_0077, 4'h9, 32'h0,         1'b0};
        tbl[13] = '{1'b0, BASE + 32'hFFC, 32'h0,         4'h0, 32'h99BB_CC77, 1'b0};
        for (int i = 0; i < 14; i++) begin
            run_txn(1, tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, rd, er, acc);
            chk($sformatf("tbl[%0d] rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("tbl[%0d] err", i), 32'(er), 32'(tbl[i].exp_err));
        end

        // Backpressure: read held with rsp_ready low for 3 cycles.
        @(negedge clk);
        rsp_ready[1] = 1'b0;
        req_valid[1] = 1'b1;
        req_wen[1]   = 1'b0;
        req_addr[1]  = BASE + 32'h10;
        @(negedge clk);
        n = 0;
        while (!rsp_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp rsp_valid rises", 32'(rsp_valid[1]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp[%0d] rsp_valid", i), 32'(rsp_valid[1]), 32'd1);
            chk($sformatf("bp[%0d] rsp_rdata", i), rsp_rdata[1], 32'hDEAD_AAEF);
            chk($sformatf("bp[%0d] req_ready", i), 32'(req_ready[1]), 32'd0);
            if (i < 2) @(negedge clk);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("bp release rsp_valid", 32'(rsp_valid[1]), 32'd0);
        chk("bp release req_ready", 32'(req_ready[1]), 32'd1);

        // Reset in BUSY on the LATENCY=5 instance: write stays, response never shows.
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_wen[2]   = 1'b1;
        req_addr[2]  = BASE + 32'h20;
        req_wdata[2] = 32'h5A5A_5A5A;
        req_wmask[2] = 4'hF;
        chk("rst pre req_ready", 32'(req_ready[2]), 32'd1);
        @(negedge clk);
        req_valid[2] = 1'b0;
        rst_n[2]     = 1'b0;
        model_write(2, BASE + 32'h20, 32'h5A5A_5A5A, 4'hF);
        @(negedge clk);
        rst_n[2] = 1'b1;
        chk("rst req_ready after reset edge", 32'(req_ready[2]), 32'd1);
        @(negedge clk);
        chk("rst req_ready after release", 32'(req_ready[2]), 32'd1);
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid[2]) quiet = 1'b0;
            @(negedge clk);
        end
        chk("rst response discarded", 32'(quiet), 32'd1);
        run_txn(2, 1'b0, BASE + 32'h20, 32'h0, 4'h0, rd, er, acc);
        chk("rst write committed", rd, 32'h5A5A_5A5A);

        // Throughput sweep: 8 back-to-back writes then 8 back-to-back reads per latency.
        for (int d = 0; d < 3; d++) begin
            prev = -1;
            for (int i = 0; i < 16; i++) begin
                run_txn(d, (i < 8), BASE + 32'h100 + 32'(4 * (i % 8)), $urandom(), 4'hF,
                        rd, er, acc);
                if (i != 0 && i != 8)
                    chk($sformatf("spacing d%0d i%0d", d, i), 32'(acc - prev), 32'(lat_of(d) + 1));
                prev = acc;
            end
        end

        // Random traffic against the reference model.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 40; i++) begin
                logic [31:0] a;
                int r = $urandom_range(0, 9);
                if (r < 7)       a = BASE + 32'h200 + 32'(4 * $urandom_range(0, 7));
                else if (r == 7) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 255));
                else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 64));
                else             a = $urandom();
                a = a | 32'($urandom_range(0, 3));
                run_txn(d, 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
                        rd, er, acc);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
